osc_menu_nav: RTL and testbench
===============================

// Module: osc_menu_nav
// PURPOSE
//  Parametrised two-level menu navigator for the oscilloscope UI; generalises the fixed
//  ancho/color/xn/yn menu FSM to N_ITEMS top entries, each with its own option count.
//  Consumes edge-detected ev_* pulses from buttons/keyboard; drives item/option cursors
//  to the on-screen menu renderer and holds the committed setting of every item.
//  Adds back event, optional wrap-around, open-at-current-setting and inactivity timeout.
// PARAMETERS
//  N_ITEMS      4            number of top-level menu items (>=2)
//  MAX_OPTS     4            max selectable options per item, excluding VOLVER (>=1)
//  OPT_CNT      {4'd2,4'd2,4'd4,4'd3}  packed, item i at [4i+3:4i]: options of item i, 1..MAX_OPTS
//  WRAP         1            1: cursors wrap at ends; 0: cursors saturate
//  TIMEOUT_CYC  1000         idle cycles in OPEN before forced close; 0 disables
// PORTS
//  clk            in   1                 system clock (DCM output)
//  rst            in   1                 synchronous, active-high reset
//  ev_up_pe       in   1                 one-cycle up event
//  ev_down_pe     in   1                 one-cycle down event
//  ev_ok_pe       in   1                 one-cycle select event
//  ev_back_pe     in   1                 one-cycle back/escape event
//  menu_open      out  1                 0 = BROWSE (item cursor), 1 = OPEN (option cursor)
//  item_idx       out  IDX_W             current item, IDX_W = $clog2(N_ITEMS)
//  opt_idx        out  OPT_W             option cursor; value OPT_CNT[item] = VOLVER; OPT_W = $clog2(MAX_OPTS+1)
//  settings       out  N_ITEMS*OPT_W     committed option of item i at [i*OPT_W +: OPT_W]
//  commit_pulse   out  1                 one cycle high when a setting is written
//  menu_timeout   out  1                 one cycle high when timeout closes the menu
// BEHAVIOUR
//  - All outputs registered. Reset: BROWSE, item_idx=0, opt_idx=0, settings=0, pulses=0, idle counter=0.
//  - Event priority per cycle: rst > ev_ok_pe > ev_back_pe > (ev_up_pe xor ev_down_pe);
//    up and down together with no ok/back: no change. Lower-priority events that cycle are dropped.
//  - BROWSE: up -> item_idx-1, down -> item_idx+1 over 0..N_ITEMS-1 (WRAP=1: wrap, else saturate);
//    ok -> OPEN next cycle, opt_idx loaded with settings of that item; back -> no effect.
//  - OPEN: up/down move opt_idx over 0..OPT_CNT[item_idx] (VOLVER is the top value), wrap/saturate
//    per WRAP; item_idx frozen.
//    ok on option k<OPT_CNT: settings[item]<=k, commit_pulse=1 next cycle, go BROWSE.
//    ok on VOLVER or back: go BROWSE, settings unchanged, no commit_pulse.
//  - Update latency: one clock from event to outputs. opt_idx is don't-care-but-stable in
//    BROWSE (holds last value).
//  - Timeout: idle counter counts clk cycles in OPEN, cleared by any ev_* and on entry to OPEN;
//    reaching TIMEOUT_CYC-1 with no event -> BROWSE, menu_timeout=1, no commit. An event arriving
//    in the expiry cycle takes precedence and clears the counter. Counter held 0 in BROWSE
//    and when TIMEOUT_CYC=0.
//  - Counter width $clog2(TIMEOUT_CYC+1); comparisons unsigned; no arithmetic overflow reachable.
//  - rst mid-operation: immediate return to reset values on next edge, settings cleared.
//  - Illegal state encoding -> BROWSE with cursors cleared.
// STRUCTURE
//  - osc_menu_pkg: state encodings MENU_BROWSE/MENU_OPEN, function opt_cnt_of(item) extracting OPT_CNT
//    field, function cursor_step(cur,max,dir,wrap) shared by item and option cursors.
//  - Sub-module osc_menu_idle_timer (parameter TIMEOUT_CYC; inputs clr, en; output expire).
//  - Top: FSM + cursor regs + settings register bank; one comb next-state block, one seq block.
// TESTING (defaults, WRAP=1, TIMEOUT_CYC=1000)
//  1 rst, then down x3, up x1 -> item_idx 1,2,3,2; up x3 from 2 -> 1,0,3 (wrap); menu_open=0.
//  2 item 1: ok, down x2, ok -> menu_open 1 then 0, settings[1]=2, commit_pulse one cycle.
//  3 item 0 reopened after setting 1: ok -> opt_idx=1; up,up,up -> 0,3(VOLVER),2; down, ok -> on
//    VOLVER(3) back to BROWSE, settings[0] unchanged, no commit_pulse.
//  4 WRAP=0 variant: item 0 up -> stays 0; item 3 down -> stays 3; OPEN item 2, down x5 -> opt_idx 2.
//  5 OPEN, idle 1000 cycles -> menu_timeout pulse at cycle 1000, BROWSE, settings unchanged;
//    event at cycle 999 -> no timeout, counter restarts.
//  6 up+down same cycle -> no move; ok+down in OPEN -> commit of pre-move option; rst while OPEN
//    with settings nonzero -> all outputs reset values next cycle.

Source files
------------

// File: rtl/osc_menu_pkg.sv
// -----------------------------------------------------------------------------
// osc_menu_pkg
//   Shared types and helpers for the oscilloscope menu navigator.
//   - menu_state_e : BROWSE (item cursor active) / OPEN (option cursor active)
//   - step_dir_e   : decoded cursor movement for one cycle
//   - opt_cnt_of   : extracts the option count of one item from the packed
//                    per-item option-count vector
//   - cursor_step  : one up/down step of a cursor over 0..last, wrapping or
//                    saturating; shared by the item and option cursors
// -----------------------------------------------------------------------------
package osc_menu_pkg;

    // Each item's option count occupies a 4-bit field of the packed vector.
    localparam int OPT_FIELD_W = 4;
    // Upper bound on items so the helpers can use one fixed vector width.
    localparam int MAX_ITEMS   = 16;
    localparam int OPT_VEC_W   = MAX_ITEMS * OPT_FIELD_W;
    // Common width for cursor arithmetic; callers size-cast in and out.
    localparam int CUR_W       = 8;

    typedef enum logic [1:0] {
        MENU_BROWSE = 2'b00,
        MENU_OPEN   = 2'b01
    } menu_state_e;

    // "Up" on screen moves towards index 0, so it decrements the cursor.
    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_DEC  = 2'b01,
        STEP_INC  = 2'b10
    } step_dir_e;

    function automatic logic [OPT_FIELD_W-1:0] opt_cnt_of(
        input logic [OPT_VEC_W-1:0] opt_cnt,
        input logic [CUR_W-1:0]     item
    );
        logic [OPT_VEC_W-1:0] shifted;
        shifted = opt_cnt >> (OPT_FIELD_W * item);
        return shifted[OPT_FIELD_W-1:0];
    endfunction

    function automatic logic [CUR_W-1:0] cursor_step(
        input logic [CUR_W-1:0] cur,
        input logic [CUR_W-1:0] last,
        input step_dir_e        dir,
        input logic             wrap
    );
        logic [CUR_W-1:0] nxt;
        nxt = cur;
        case (dir)
            STEP_DEC: begin
                if (cur == '0) nxt = wrap ? last : '0;
                else           nxt = cur - CUR_W'(1);
            end
            STEP_INC: begin
                if (cur >= last) nxt = wrap ? '0 : last;
                else             nxt = cur + CUR_W'(1);
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/osc_menu_nav_if.sv
// -----------------------------------------------------------------------------
// osc_menu_nav_if
//   Connects the button/keyboard event front end to the menu navigator and the
//   navigator to the on-screen menu renderer.
//   Events (front end -> navigator), one-cycle pulses:
//     ev_up_pe, ev_down_pe, ev_ok_pe, ev_back_pe
//   State (navigator -> renderer / settings consumers):
//     menu_open     0 = BROWSE, 1 = OPEN
//     item_idx      current item
//     opt_idx       option cursor (value OPT_CNT[item] is VOLVER)
//     settings      committed option of item i at [i*OPT_W +: OPT_W]
//     commit_pulse  one cycle high when a setting is written
//     menu_timeout  one cycle high when inactivity closes the menu
//   modport master : event source (drives events, observes state)
//   modport slave  : the navigator (consumes events, drives state)
// -----------------------------------------------------------------------------
interface osc_menu_nav_if #(
    parameter int N_ITEMS  = 4,
    parameter int MAX_OPTS = 4
);
    localparam int IDX_W = $clog2(N_ITEMS);
    localparam int OPT_W = $clog2(MAX_OPTS + 1);

    logic                       ev_up_pe;
    logic                       ev_down_pe;
    logic                       ev_ok_pe;
    logic                       ev_back_pe;

    logic                       menu_open;
    logic [IDX_W-1:0]           item_idx;
    logic [OPT_W-1:0]           opt_idx;
    logic [N_ITEMS*OPT_W-1:0]   settings;
    logic                       commit_pulse;
    logic                       menu_timeout;

    modport master (
        output ev_up_pe, ev_down_pe, ev_ok_pe, ev_back_pe,
        input  menu_open, item_idx, opt_idx, settings, commit_pulse, menu_timeout
    );

    modport slave (
        input  ev_up_pe, ev_down_pe, ev_ok_pe, ev_back_pe,
        output menu_open, item_idx, opt_idx, settings, commit_pulse, menu_timeout
    );

endinterface

// File: rtl/osc_menu_idle_timer.sv
// -----------------------------------------------------------------------------
// osc_menu_idle_timer
//   Counts idle cycles while enabled and flags expiry on the cycle the count
//   reaches TIMEOUT_CYC-1 with no clear. The count is forced to zero whenever
//   the timer is disabled, cleared, or expires; TIMEOUT_CYC = 0 disables it.
//   Ports:
//     clk     in   system clock
//     rst     in   synchronous, active-high reset
//     clr     in   any user event this cycle; restarts the count, wins over expiry
//     en      in   menu is OPEN
//     expire  out  combinational expiry strobe, consumed by the navigator FSM
// -----------------------------------------------------------------------------
module osc_menu_idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int               CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic             ENABLED = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    assign expire  = ENABLED && en && !clr && at_last;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (!ENABLED || !en || clr || at_last) cnt_d = '0;
        else                                   cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/osc_menu_nav.sv
// -----------------------------------------------------------------------------
// osc_menu_nav
//   Two-level menu navigator for the oscilloscope UI. In BROWSE the up/down
//   events move the item cursor; ok opens the item with the option cursor
//   placed on that item's committed setting. In OPEN up/down move the option
//   cursor over 0..OPT_CNT[item], where the top value is VOLVER (return);
//   ok on a real option commits it, ok on VOLVER or back closes without
//   committing, and an idle period of TIMEOUT_CYC cycles closes the menu.
//   Parameters:
//     N_ITEMS      number of items (>= 2)
//     MAX_OPTS     largest per-item option count, VOLVER excluded (>= 1)
//     OPT_CNT      packed option counts, item i at [4i+3:4i]
//     WRAP         1: cursors wrap at the ends; 0: cursors saturate
//     TIMEOUT_CYC  idle cycles in OPEN before forced close; 0 disables
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous, active-high reset
//     bus   slave modport of osc_menu_nav_if (events in, menu state out)
//   Event priority per cycle: rst > ok > back > (up xor down); every output
//   is driven from a register and updates one clock after the event.
// -----------------------------------------------------------------------------
module osc_menu_nav
    import osc_menu_pkg::*;
#(
    parameter int                   N_ITEMS     = 4,
    parameter int                   MAX_OPTS    = 4,
    parameter logic [4*N_ITEMS-1:0] OPT_CNT     = {4'd2, 4'd2, 4'd4, 4'd3},
    parameter bit                   WRAP        = 1'b1,
    parameter int                   TIMEOUT_CYC = 1000
) (
    input logic           clk,
    input logic           rst,
    osc_menu_nav_if.slave bus
);

    localparam int                   IDX_W       = $clog2(N_ITEMS);
    localparam int                   OPT_W       = $clog2(MAX_OPTS + 1);
    localparam logic [OPT_VEC_W-1:0] OPT_CNT_EXT = OPT_VEC_W'(OPT_CNT);

    menu_state_e                   state_q, state_d;
    logic [IDX_W-1:0]              item_idx_q, item_idx_d;
    logic [OPT_W-1:0]              opt_idx_q, opt_idx_d;
    logic [N_ITEMS-1:0][OPT_W-1:0] settings_q, settings_d;
    logic                          commit_q, commit_d;
    logic                          timeout_q, timeout_d;

    step_dir_e                     dir;
    logic                          any_ev;
    logic                          expire;
    logic [OPT_W-1:0]              cur_opt_cnt;

    // up and down together cancel; either alone moves the cursor.
    assign dir = (bus.ev_up_pe ^ bus.ev_down_pe)
               ? (bus.ev_up_pe ? STEP_DEC : STEP_INC)
               : STEP_NONE;

    // Any asserted event counts as activity, even one the FSM then drops.
    assign any_ev = bus.ev_up_pe | bus.ev_down_pe | bus.ev_ok_pe | bus.ev_back_pe;

    // Option count of the current item; this value itself is VOLVER.
    assign cur_opt_cnt = OPT_W'(opt_cnt_of(OPT_CNT_EXT, CUR_W'(item_idx_q)));

    osc_menu_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (any_ev),
        .en     (state_q == MENU_OPEN),
        .expire (expire)
    );

    always_comb begin
        state_d    = state_q;
        item_idx_d = item_idx_q;
        opt_idx_d  = opt_idx_q;
        settings_d = settings_q;
        commit_d   = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            MENU_BROWSE: begin
                if (bus.ev_ok_pe) begin
                    state_d   = MENU_OPEN;
                    opt_idx_d = settings_q[item_idx_q];
                end else if (!bus.ev_back_pe) begin
                    item_idx_d = IDX_W'(cursor_step(CUR_W'(item_idx_q), CUR_W'(N_ITEMS - 1),
                                                    dir, WRAP));
                end
            end

            MENU_OPEN: begin
                if (bus.ev_ok_pe) begin
                    // Commit uses the cursor before any same-cycle up/down.
                    if (opt_idx_q < cur_opt_cnt) begin
                        settings_d[item_idx_q] = opt_idx_q;
                        commit_d               = 1'b1;
                    end
                    state_d = MENU_BROWSE;
                end else if (bus.ev_back_pe) begin
                    state_d = MENU_BROWSE;
                end else if (expire) begin
                    state_d   = MENU_BROWSE;
                    timeout_d = 1'b1;
                end else begin
                    opt_idx_d = OPT_W'(cursor_step(CUR_W'(opt_idx_q), CUR_W'(cur_opt_cnt),
                                                   dir, WRAP));
                end
            end

            default: begin
                state_d    = MENU_BROWSE;
                item_idx_d = '0;
                opt_idx_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MENU_BROWSE;
            item_idx_q <= '0;
            opt_idx_q  <= '0;
            // NOTE: the settings bank is reset explicitly; a reset must restore
            // the power-on defaults, so it cannot be left to RAM-style inference.
            settings_q <= '0;
            commit_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            item_idx_q <= item_idx_d;
            opt_idx_q  <= opt_idx_d;
            settings_q <= settings_d;
            commit_q   <= commit_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.menu_open    = (state_q == MENU_OPEN);
    assign bus.item_idx     = item_idx_q;
    assign bus.opt_idx      = opt_idx_q;
    assign bus.settings     = settings_q;
    assign bus.commit_pulse = commit_q;
    assign bus.menu_timeout = timeout_q;

endmodule

// File: tb/tb_osc_menu_nav.sv
// -----------------------------------------------------------------------------
// tb_osc_menu_nav
//   Two navigators share one event stream: A (WRAP=1, TIMEOUT_CYC=1000) and
//   B (WRAP=0, TIMEOUT_CYC=7). A behavioural model of the menu rules tracks
//   both and is compared with every output on every falling edge; directed
//   sequences add literal expectations, then randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_osc_menu_nav;

    localparam int                N_ITEMS  = 4;
    localparam int                MAX_OPTS = 4;
    localparam int                IDX_W    = 2;
    localparam int                OPT_W    = 3;
    localparam logic [15:0]       OPT_CNT  = {4'd2, 4'd2, 4'd4, 4'd3};
    localparam int                TMO_A    = 1000;
    localparam int                TMO_B    = 7;

    logic clk = 1'b0;
    logic rst;
    logic ev_up, ev_down, ev_ok, ev_back;
    bit   chk_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    osc_menu_nav_if #(.N_ITEMS(N_ITEMS), .MAX_OPTS(MAX_OPTS)) if_a ();
    osc_menu_nav_if #(.N_ITEMS(N_ITEMS), .MAX_OPTS(MAX_OPTS)) if_b ();

    assign if_a.ev_up_pe   = ev_up;
    assign if_a.ev_down_pe = ev_down;
    assign if_a.ev_ok_pe   = ev_ok;
    assign if_a.ev_back_pe = ev_back;
    assign if_b.ev_up_pe   = ev_up;
    assign if_b.ev_down_pe = ev_down;
    assign if_b.ev_ok_pe   = ev_ok;
    assign if_b.ev_back_pe = ev_back;

    osc_menu_nav #(
        .N_ITEMS(N_ITEMS), .MAX_OPTS(MAX_OPTS), .OPT_CNT(OPT_CNT),
        .WRAP(1'b1), .TIMEOUT_CYC(TMO_A)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    osc_menu_nav #(
        .N_ITEMS(N_ITEMS), .MAX_OPTS(MAX_OPTS), .OPT_CNT(OPT_CNT),
        .WRAP(1'b0), .TIMEOUT_CYC(TMO_B)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // ---------------- reference model ----------------
    // Option counts decoded by hand from OPT_CNT = {2,2,4,3}: item 0 is the low nibble.
    int opt_cnt_tab [N_ITEMS] = '{3, 4, 2, 2};
    bit m_wrap      [2]       = '{1'b1, 1'b0};
    int m_tmo_cyc   [2]       = '{TMO_A, TMO_B};

    bit m_open   [2];
    int m_item   [2];
    int m_opt    [2];
    int m_idle   [2];
    int m_set    [2][N_ITEMS];
    bit m_commit [2];
    bit m_tmo    [2];

    // Position after moving delta steps on a ring (wrap) or a clamped line of 0..top.
    function automatic int move(input int cur, input int top, input int delta, input bit wrap);
        int n;
        n = cur + delta;
        if (wrap) return (n + top + 1) % (top + 1);
        if (n < 0) return 0;
        if (n > top) return top;
        return n;
    endfunction

    task automatic model_step(input int k);
        int  delta;
        bit  any;
        m_commit[k] = 1'b0;
        m_tmo[k]    = 1'b0;
        if (rst) begin
            m_open[k] = 1'b0;
            m_item[k] = 0;
            m_opt[k]  = 0;
            m_idle[k] = 0;
            for (int i = 0; i < N_ITEMS; i++) m_set[k][i] = 0;
            return;
        end
        delta = (ev_up && !ev_down) ? -1 : ((ev_down && !ev_up) ? 1 : 0);
        any   = ev_up | ev_down | ev_ok | ev_back;
        if (!m_open[k]) begin
            if (ev_ok) begin
                m_open[k] = 1'b1;
                m_opt[k]  = m_set[k][m_item[k]];
                m_idle[k] = 0;
            end else if (!ev_back) begin
                m_item[k] = move(m_item[k], N_ITEMS - 1, delta, m_wrap[k]);
            end
        end else if (ev_ok) begin
            if (m_opt[k] < opt_cnt_tab[m_item[k]]) begin
                m_set[k][m_item[k]] = m_opt[k];
                m_commit[k]         = 1'b1;
            end
            m_open[k] = 1'b0;
        end else if (ev_back) begin
            m_open[k] = 1'b0;
        end else if (any) begin
            m_idle[k] = 0;
            m_opt[k]  = move(m_opt[k], opt_cnt_tab[m_item[k]], delta, m_wrap[k]);
        end else begin
            m_idle[k]++;
            if (m_tmo_cyc[k] > 0 && m_idle[k] == m_tmo_cyc[k]) begin
                m_open[k] = 1'b0;
                m_tmo[k]  = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int k, input logic open, input logic [IDX_W-1:0] item,
                           input logic [OPT_W-1:0] opt, input logic [N_ITEMS*OPT_W-1:0] set,
                           input logic commit, input logic tmo);
        string                    tag;
        logic [N_ITEMS*OPT_W-1:0] es;
        tag = (k == 0) ? "A" : "B";
        for (int i = 0; i < N_ITEMS; i++) es[i*OPT_W +: OPT_W] = OPT_W'(m_set[k][i]);
        check({tag, "_menu_open"},    32'(open),   32'(m_open[k]));
        check({tag, "_item_idx"},     32'(item),   32'(m_item[k]));
        check({tag, "_opt_idx"},      32'(opt),    32'(m_opt[k]));
        check({tag, "_settings"},     32'(set),    32'(es));
        check({tag, "_commit_pulse"}, 32'(commit), 32'(m_commit[k]));
        check({tag, "_menu_timeout"}, 32'(tmo),    32'(m_tmo[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, if_a.menu_open, if_a.item_idx, if_a.opt_idx, if_a.settings,
                    if_a.commit_pulse, if_a.menu_timeout);
            cmp_dut(1, if_b.menu_open, if_b.item_idx, if_b.opt_idx, if_b.settings,
                    if_b.commit_pulse, if_b.menu_timeout);
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input bit u, input bit d, input bit o, input bit b, input bit r = 1'b0);
        ev_up   = u;
        ev_down = d;
        ev_ok   = o;
        ev_back = b;
        rst     = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) apply(0, 0, 0, 0);
    endtask

    int t1_dir [7] = '{1, 1, 1, -1, -1, -1, -1};
    int t1_exp [7] = '{1, 2, 3, 2, 1, 0, 3};
    int t3_exp [3] = '{0, 3, 2};

    initial begin
        ev_up = 1'b0; ev_down = 1'b0; ev_ok = 1'b0; ev_back = 1'b0; rst = 1'b1;
        @(negedge clk);
        apply(0, 0, 0, 0, 1);
        chk_en = 1'b1;

        // Reset values
        check("rst_menu_open", 32'(if_a.menu_open), 0);
        check("rst_item_idx",  32'(if_a.item_idx), 0);
        check("rst_opt_idx",   32'(if_a.opt_idx), 0);
        check("rst_settings",  32'(if_a.settings), 0);
        check("rst_commit",    32'(if_a.commit_pulse), 0);
        check("rst_timeout",   32'(if_a.menu_timeout), 0);

        // Item cursor with wrap
        for (int i = 0; i < 7; i++) begin
            apply(t1_dir[i] < 0, t1_dir[i] > 0, 0, 0);
            check("t1_item_idx", 32'(if_a.item_idx), 32'(t1_exp[i]));
        end
        check("t1_menu_open", 32'(if_a.menu_open), 0);
        apply(0, 1, 0, 0);
        apply(0, 1, 0, 0);
        check("t1_item_back_to_1", 32'(if_a.item_idx), 1);

        // Item 1: open, move to option 2, commit
        apply(0, 0, 1, 0);
        check("t2_open", 32'(if_a.menu_open), 1);
        check("t2_opt_load", 32'(if_a.opt_idx), 0);
        apply(0, 1, 0, 0);
        apply(0, 1, 0, 0);
        check("t2_opt_2", 32'(if_a.opt_idx), 2);
        apply(0, 0, 1, 0);
        check("t2_closed", 32'(if_a.menu_open), 0);
        check("t2_commit", 32'(if_a.commit_pulse), 1);
        check("t2_settings", 32'(if_a.settings), 32'h010);
        idle(1);
        check("t2_commit_one_cycle", 32'(if_a.commit_pulse), 0);

        // Item 0: set option 1, reopen at it, walk through VOLVER, exit on VOLVER
        apply(1, 0, 0, 0);
        check("t3_item_0", 32'(if_a.item_idx), 0);
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 1, 0);
        check("t3_settings_set", 32'(if_a.settings), 32'h011);
        apply(0, 0, 1, 0);
        check("t3_reopen_opt", 32'(if_a.opt_idx), 1);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0);
            check("t3_opt_walk", 32'(if_a.opt_idx), 32'(t3_exp[i]));
        end
        apply(0, 1, 0, 0);
        check("t3_on_volver", 32'(if_a.opt_idx), 3);
        apply(0, 0, 1, 0);
        check("t3_volver_closed", 32'(if_a.menu_open), 0);
        check("t3_volver_no_commit", 32'(if_a.commit_pulse), 0);
        check("t3_volver_settings", 32'(if_a.settings), 32'h011);

        // Simultaneous events
        apply(1, 1, 0, 0);
        check("t6_updown_no_move", 32'(if_a.item_idx), 0);
        apply(0, 0, 1, 0);
        apply(0, 1, 0, 0);
        check("t6_opt_2", 32'(if_a.opt_idx), 2);
        apply(0, 1, 1, 0);
        check("t6_okdown_commit", 32'(if_a.commit_pulse), 1);
        check("t6_okdown_settings", 32'(if_a.settings), 32'h012);
        apply(0, 0, 1, 0);
        check("t6_open_before_rst", 32'(if_a.menu_open), 1);
        apply(0, 1, 0, 0, 1);
        check("t6_rst_open", 32'(if_a.menu_open), 0);
        check("t6_rst_item", 32'(if_a.item_idx), 0);
        check("t6_rst_opt", 32'(if_a.opt_idx), 0);
        check("t6_rst_settings", 32'(if_a.settings), 0);

        // Saturating cursors on B
        apply(1, 0, 0, 0);
        check("t4_b_item_sat_low", 32'(if_b.item_idx), 0);
        repeat (4) apply(0, 1, 0, 0);
        check("t4_b_item_sat_high", 32'(if_b.item_idx), 3);
        apply(1, 0, 0, 0);
        apply(0, 0, 1, 0);
        check("t4_b_open_item2", 32'(if_b.menu_open), 1);
        repeat (5) apply(0, 1, 0, 0);
        check("t4_b_opt_sat", 32'(if_b.opt_idx), 2);
        apply(0, 0, 0, 1);
        check("t4_b_back_closed", 32'(if_b.menu_open), 0);

        // Inactivity timeout on A
        apply(0, 0, 0, 0, 1);
        apply(0, 0, 1, 0);
        idle(999);
        check("t5_open_at_999", 32'(if_a.menu_open), 1);
        check("t5_no_timeout_at_999", 32'(if_a.menu_timeout), 0);
        idle(1);
        check("t5_timeout_pulse", 32'(if_a.menu_timeout), 1);
        check("t5_timeout_closed", 32'(if_a.menu_open), 0);
        check("t5_timeout_no_commit", 32'(if_a.commit_pulse), 0);
        idle(1);
        check("t5_timeout_one_cycle", 32'(if_a.menu_timeout), 0);
        apply(0, 0, 1, 0);
        idle(999);
        apply(0, 1, 0, 0);
        check("t5_event_wins_open", 32'(if_a.menu_open), 1);
        check("t5_event_wins_no_tmo", 32'(if_a.menu_timeout), 0);
        idle(999);
        check("t5_restart_open", 32'(if_a.menu_open), 1);
        idle(1);
        check("t5_restart_timeout", 32'(if_a.menu_timeout), 1);

        // Randomized traffic: sparse events (lets B time out), then dense
        repeat (2500) begin
            apply($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                  $urandom_range(0, 299) == 0);
        end
        repeat (1500) begin
            apply($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 499) == 0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
